// File: rtl/tile_load_sequencer.sv
// Tile load sequencer: turns one valid/ready word stream into write beats for kernel_mem,
// input_mem and overlap_cache. Optional overlap phase enabled by TILE_LOADER_OVERLAP_EN.
module tile_load_sequencer #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int INPUT_WORDS   = 16384,
    parameter int KERNEL_WORDS  = 512,
    parameter int OVERLAP_WORDS = 256
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     load_start,
    input  logic                     load_kernel,
    input  logic [IO_DATA_WIDTH-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [IO_DATA_WIDTH-1:0] wr_addr,
    output logic [IO_DATA_WIDTH-1:0] wr_data,
    output logic                     int_mem_we,
    output logic                     overlap_cache_we,
    output logic                     data_ready,
    input  logic                     fsm_done,
    output logic                     busy
);

    localparam int MAX_KI    = (INPUT_WORDS > KERNEL_WORDS) ? INPUT_WORDS : KERNEL_WORDS;
    localparam int MAX_WORDS = (MAX_KI > OVERLAP_WORDS) ? MAX_KI : OVERLAP_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS);

    localparam logic [CNT_W-1:0] KERN_LAST  = CNT_W'(KERNEL_WORDS - 1);
    localparam logic [CNT_W-1:0] INPUT_LAST = CNT_W'(INPUT_WORDS - 1);
`ifdef TILE_LOADER_OVERLAP_EN
    localparam logic [CNT_W-1:0] OVL_LAST   = CNT_W'(OVERLAP_WORDS - 1);
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LD_KERNEL  = 3'd1,
        LD_INPUT   = 3'd2,
`ifdef TILE_LOADER_OVERLAP_EN
        LD_OVERLAP = 3'd3,
`endif
        READY      = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   next_load_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [IO_DATA_WIDTH-1:0] beat_addr_s;
    logic                     phase_last_s;

`ifdef TILE_LOADER_OVERLAP_EN
    logic ov_we_r;
    assign overlap_cache_we = ov_we_r;
`else
    assign overlap_cache_we = 1'b0;
`endif

    assign s_ready = (state_r == LD_KERNEL) || (state_r == LD_INPUT)
`ifdef TILE_LOADER_OVERLAP_EN
                     || (state_r == LD_OVERLAP)
`endif
                     ;
    assign busy = (state_r != IDLE);

    // Per-phase beat address, last-word detect and successor state
    always_comb begin
        beat_addr_s  = IO_DATA_WIDTH'(cnt_r);
        phase_last_s = 1'b0;
        next_load_s  = state_r;
        case (state_r)
            LD_KERNEL: begin
                beat_addr_s[IO_DATA_WIDTH-1] = 1'b1;
                phase_last_s = (cnt_r == KERN_LAST);
                next_load_s  = LD_INPUT;
            end
            LD_INPUT: begin
                phase_last_s = (cnt_r == INPUT_LAST);
`ifdef TILE_LOADER_OVERLAP_EN
                next_load_s  = LD_OVERLAP;
`else
                next_load_s  = READY;
`endif
            end
`ifdef TILE_LOADER_OVERLAP_EN
            LD_OVERLAP: begin
                phase_last_s = (cnt_r == OVL_LAST);
                next_load_s  = READY;
            end
`endif
            default: begin
                phase_last_s = 1'b0;
                next_load_s  = state_r;
            end
        endcase
    end

    // Sequencer state, word counter and registered write-beat outputs
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            int_mem_we <= 1'b0;
            data_ready <= 1'b0;
`ifdef TILE_LOADER_OVERLAP_EN
            ov_we_r    <= 1'b0;
`endif
        end else begin
            int_mem_we <= 1'b0;
`ifdef TILE_LOADER_OVERLAP_EN
            ov_we_r    <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    data_ready <= 1'b0;
                    if (load_start) begin
                        cnt_r   <= '0;
                        state_r <= load_kernel ? LD_KERNEL : LD_INPUT;
                    end
                end
                LD_KERNEL, LD_INPUT: begin
                    if (s_valid) begin
                        wr_addr    <= beat_addr_s;
                        wr_data    <= s_data;
                        int_mem_we <= 1'b1;
                        if (phase_last_s) begin
                            cnt_r   <= '0;
                            state_r <= next_load_s;
                        end else begin
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end
                end
`ifdef TILE_LOADER_OVERLAP_EN
                LD_OVERLAP: begin
                    if (s_valid) begin
                        wr_addr <= beat_addr_s;
                        wr_data <= s_data;
                        ov_we_r <= 1'b1;
                        if (phase_last_s) begin
                            cnt_r   <= '0;
                            state_r <= next_load_s;
                        end else begin
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end
                end
`endif
                READY: begin
                    // data_ready rises one cycle after the final beat and drops after fsm_done
                    if (fsm_done) begin
                        data_ready <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        data_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
